y_demux2_reg: RTL and testbench
===============================

// Module: y_demux2_reg
// PURPOSE
//  Registered 1-to-2 demultiplexer: the routing counterpart of yMux2. It steers one
//  SIZE-bit input stream to one of two output channels, chosen per word by sel.
//  Each channel has a one-entry output register and a valid/ready handshake.
//  It sits between a single producer and two consumers in the datapath labs.
//  Per-channel transfer counters support bench checking.
// PARAMETERS
//  SIZE   2  data width in bits (same default as yMux2)
//  CNT_W  8  width of each per-channel accepted-word counter
// PORTS
//  clk       in   1       rising-edge clock; sole clock of the block
//  reset     in   1       synchronous, active-high reset
//  in_valid  in   1       producer offers in_data/in_sel this cycle
//  in_ready  out  1       block accepts the offer this cycle (combinational)
//  in_data   in   SIZE    input word
//  in_sel    in   1       destination: 0 -> channel 0, 1 -> channel 1
//  o0_valid  out  1       channel 0 register holds a word
//  o0_ready  in   1       channel 0 consumer takes the word this cycle
//  o0_data   out  SIZE    channel 0 word
//  o1_valid  out  1       channel 1 register holds a word
//  o1_ready  in   1       channel 1 consumer takes the word this cycle
//  o1_data   out  SIZE    channel 1 word
//  cnt0      out  CNT_W   number of words accepted for channel 0
//  cnt1      out  CNT_W   number of words accepted for channel 1
// BEHAVIOUR
//  - Reset (sync, high): on the next edge, o0/o1_valid=0, o0/o1_data=0, cnt0=cnt1=0.
//    Reset overrides any accept or drain in the same cycle; a word offered then is dropped.
//  - Each channel k has two states: EMPTY (ok_valid=0) and FULL (ok_valid=1).
//  - in_ready = in_sel ? (!o1_valid | o1_ready) : (!o0_valid | o0_ready).
//    It depends combinationally on in_sel and the ready of the selected channel only.
//  - accept = in_valid & in_ready. On accept, at the edge the selected channel loads in_data
//    and becomes FULL, and its counter increments. Latency is 1 cycle from offer to ok_valid.
//  - drain_k = ok_valid & ok_ready. At the edge, the channel becomes EMPTY unless it is
//    reloaded by an accept in the same cycle. Drain plus reload gives FULL with the new data
//    and allows one word per cycle of throughput per channel.
//  - While ok_valid=1 and ok_ready=0, ok_data is held stable.
//  - The unselected channel drains independently in the same cycle. The two channels never
//    block each other.
//  - If in_valid=1 and in_ready=0, there is no state change for the input.
//  - ok_data after a drain keeps its last value (don't-care for consumers).
//  - Counters wrap modulo 2^CNT_W and never saturate.
//  - ok_ready while EMPTY is ignored. in_data/in_sel are ignored when in_valid=0.
// TESTING
//  1. Assert reset for 1 edge -> o0_valid=o1_valid=0, cnt0=cnt1=0, in_ready=1.
//  2. in_valid=1, in_sel=0, in_data=2'd3, o0_ready=0 -> next cycle o0_valid=1, o0_data=3,
//     o1_valid=0, cnt0=1.
//  3. o1_ready=0; send 2'd1 to ch1, then offer 2'd2 to ch1 -> in_ready=0 and o1_data stays 1.
//     Switch in_sel=0 with data 2'd2 -> accepted, o0_data=2.
//  4. Ch0 FULL, o0_ready=1, offer 2'd1 with sel=0 -> in_ready=1; next cycle o0_valid=1,
//     o0_data=1, cnt0 increments.
//  5. 256 consecutive accepts to ch1 with o1_ready=1 -> cnt1 returns to 0; cnt0 unchanged.
//  6. Both channels FULL and in_valid=1, assert reset -> next edge all valid=0 and counters=0;
//     the offered word never appears.
//  7. Exhaustive sweep: all in_data (0..3) x in_sel (0..1), consumers ready -> each word
//     appears on the selected channel exactly 1 cycle later.

Source files
------------

// File: rtl/y_demux2_reg.sv
// rtl/y_demux2_reg.sv - registered 1-to-2 demultiplexer with per-channel valid/ready and counters
// Each channel is a one-entry register; a drain and a reload in the same cycle sustain full rate.
module y_demux2_reg #(
   parameter int SIZE  = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SIZE-1:0]  in_data,
   input  logic             in_sel,
   output logic             o0_valid,
   input  logic             o0_ready,
   output logic [SIZE-1:0]  o0_data,
   output logic             o1_valid,
   input  logic             o1_ready,
   output logic [SIZE-1:0]  o1_data,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_FULL  = 1'b1;

   logic             r_st0;
   logic             r_st1;
   logic [SIZE-1:0]  r_data0;
   logic [SIZE-1:0]  r_data1;
   logic [CNT_W-1:0] r_cnt0;
   logic [CNT_W-1:0] r_cnt1;

   logic w_room0;
   logic w_room1;
   logic w_accept;
   logic w_acc0;
   logic w_acc1;
   logic w_drain0;
   logic w_drain1;

   assign o0_valid = (r_st0 == ST_FULL);
   assign o1_valid = (r_st1 == ST_FULL);
   assign o0_data  = r_data0;
   assign o1_data  = r_data1;
   assign cnt0     = r_cnt0;
   assign cnt1     = r_cnt1;

   // A channel has room if empty or if its word leaves this very cycle.
   assign w_room0  = !o0_valid || o0_ready;
   assign w_room1  = !o1_valid || o1_ready;
   assign in_ready = in_sel ? w_room1 : w_room0;

   assign w_accept = in_valid && in_ready;
   assign w_acc0   = w_accept && !in_sel;
   assign w_acc1   = w_accept && in_sel;
   assign w_drain0 = o0_valid && o0_ready;
   assign w_drain1 = o1_valid && o1_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_st0   <= ST_EMPTY;
         r_data0 <= '0;
         r_cnt0  <= '0;
      end else if (w_acc0) begin
         r_st0   <= ST_FULL;
         r_data0 <= in_data;
         r_cnt0  <= r_cnt0 + CNT_W'(1);
      end else if (w_drain0) begin
         r_st0   <= ST_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_st1   <= ST_EMPTY;
         r_data1 <= '0;
         r_cnt1  <= '0;
      end else if (w_acc1) begin
         r_st1   <= ST_FULL;
         r_data1 <= in_data;
         r_cnt1  <= r_cnt1 + CNT_W'(1);
      end else if (w_drain1) begin
         r_st1   <= ST_EMPTY;
      end
   end

endmodule

// File: tb/tb_y_demux2_reg.sv
// tb/tb_y_demux2_reg.sv - self-checking bench for y_demux2_reg
// Directed vector table, hand sequences for wrap/reset, then random traffic against a queue model.
module tb_y_demux2_reg;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_data;
   logic       in_sel;
   logic       o0_valid;
   logic       o0_ready;
   logic [1:0] o0_data;
   logic       o1_valid;
   logic       o1_ready;
   logic [1:0] o1_data;
   logic [7:0] cnt0;
   logic [7:0] cnt1;

   int n_tests = 0;
   int n_fail  = 0;

   y_demux2_reg #(.SIZE(2), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
      .o0_valid(o0_valid), .o0_ready(o0_ready), .o0_data(o0_data),
      .o1_valid(o1_valid), .o1_ready(o1_ready), .o1_data(o1_data),
      .cnt0(cnt0), .cnt1(cnt1)
   );

   always #5 clk = ~clk;

   // Reference model: each channel is a queue of capacity one plus a transfer count.
   logic [1:0] q0[$];
   logic [1:0] q1[$];
   logic [1:0] last0, last1;
   int         m_cnt0, m_cnt1;
   bit         m_init = 0;

   typedef struct {
      logic       rst, iv, sel;
      logic [1:0] d;
      logic       r0, r1;
      logic       e_rdy;
      logic       e_v0;
      logic [1:0] e_d0;
      logic       e_v1;
      logic [1:0] e_d1;
      logic [7:0] e_c0, e_c1;
   } vec_t;

   vec_t vt[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle; check against the model before the edge, advance the model at the edge.
   task automatic step(input logic rst, input logic iv, input logic sel, input logic [1:0] d,
                       input logic r0, input logic r1, output logic rdy_seen);
      logic e_rdy;
      reset = rst; in_valid = iv; in_sel = sel; in_data = d; o0_ready = r0; o1_ready = r1;
      @(negedge clk);
      rdy_seen = in_ready;
      e_rdy = sel ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
      if (m_init) begin
         chk("model in_ready", in_ready, e_rdy);
         chk("model o0_valid", o0_valid, q0.size() != 0);
         chk("model o1_valid", o1_valid, q1.size() != 0);
         chk("model o0_data", o0_data, last0);
         chk("model o1_data", o1_data, last1);
         chk("model cnt0", cnt0, m_cnt0);
         chk("model cnt1", cnt1, m_cnt1);
      end
      @(posedge clk);
      if (q0.size() != 0 && r0) void'(q0.pop_front());
      if (q1.size() != 0 && r1) void'(q1.pop_front());
      if (iv && e_rdy) begin
         if (sel) begin q1.push_back(d); last1 = d; m_cnt1 = (m_cnt1 + 1) % 256; end
         else     begin q0.push_back(d); last0 = d; m_cnt0 = (m_cnt0 + 1) % 256; end
      end
      if (rst) begin
         q0.delete(); q1.delete();
         last0 = 2'd0; last1 = 2'd0; m_cnt0 = 0; m_cnt1 = 0;
         m_init = 1;
      end
      #1;
   endtask

   initial begin
      logic rdy;
      vt[0]  = '{0,0,0,2'd0,0,0, 1, 0,2'd0, 0,2'd0, 8'd0,8'd0};
      vt[1]  = '{0,1,0,2'd3,0,0, 1, 1,2'd3, 0,2'd0, 8'd1,8'd0};
      vt[2]  = '{0,1,1,2'd1,0,0, 1, 1,2'd3, 1,2'd1, 8'd1,8'd1};
      vt[3]  = '{0,1,1,2'd2,0,0, 0, 1,2'd3, 1,2'd1, 8'd1,8'd1};
      vt[4]  = '{0,1,0,2'd2,1,0, 1, 1,2'd2, 1,2'd1, 8'd2,8'd1};
      vt[5]  = '{0,1,0,2'd1,1,0, 1, 1,2'd1, 1,2'd1, 8'd3,8'd1};
      vt[6]  = '{0,0,0,2'd0,1,1, 1, 0,2'd1, 0,2'd1, 8'd3,8'd1};
      vt[7]  = '{0,0,1,2'd3,1,1, 1, 0,2'd1, 0,2'd1, 8'd3,8'd1};
      vt[8]  = '{0,1,1,2'd2,0,1, 1, 0,2'd1, 1,2'd2, 8'd3,8'd2};
      vt[9]  = '{0,0,1,2'd3,0,0, 0, 0,2'd1, 1,2'd2, 8'd3,8'd2};
      vt[10] = '{0,1,0,2'd3,0,0, 1, 1,2'd3, 1,2'd2, 8'd4,8'd2};
      vt[11] = '{1,1,1,2'd1,1,1, 1, 0,2'd0, 0,2'd0, 8'd0,8'd0};

      step(1, 1, 0, 2'd2, 0, 0, rdy);
      chk("reset o0_valid", o0_valid, 0);
      chk("reset o1_valid", o1_valid, 0);
      chk("reset cnt0", cnt0, 0);
      chk("reset cnt1", cnt1, 0);

      for (int i = 0; i < 12; i++) begin
         step(vt[i].rst, vt[i].iv, vt[i].sel, vt[i].d, vt[i].r0, vt[i].r1, rdy);
         chk($sformatf("vec%0d in_ready", i), rdy, vt[i].e_rdy);
         chk($sformatf("vec%0d o0_valid", i), o0_valid, vt[i].e_v0);
         chk($sformatf("vec%0d o0_data", i), o0_data, vt[i].e_d0);
         chk($sformatf("vec%0d o1_valid", i), o1_valid, vt[i].e_v1);
         chk($sformatf("vec%0d o1_data", i), o1_data, vt[i].e_d1);
         chk($sformatf("vec%0d cnt0", i), cnt0, vt[i].e_c0);
         chk($sformatf("vec%0d cnt1", i), cnt1, vt[i].e_c1);
      end

      // Counter wrap on channel 1 at full throughput.
      step(1, 0, 0, 2'd0, 0, 0, rdy);
      for (int i = 0; i < 256; i++) begin
         step(0, 1, 1, 2'($urandom_range(0, 3)), 0, 1, rdy);
         if (i == 254) chk("wrap cnt1 at 255", cnt1, 8'd255);
      end
      chk("wrap cnt1 back to 0", cnt1, 8'd0);
      chk("wrap cnt0 untouched", cnt0, 8'd0);
      chk("wrap o1_valid", o1_valid, 1);

      // Exhaustive data x sel sweep with both consumers ready.
      for (int s = 0; s < 2; s++) begin
         for (int d = 0; d < 4; d++) begin
            step(0, 1, s[0], d[1:0], 1, 1, rdy);
            chk($sformatf("sweep s%0d d%0d valid", s, d), s ? o1_valid : o0_valid, 1);
            chk($sformatf("sweep s%0d d%0d data", s, d), s ? o1_data : o0_data, d);
         end
      end

      // Reset with both channels full and a word on offer.
      step(0, 1, 0, 2'd1, 0, 0, rdy);
      step(0, 1, 1, 2'd2, 0, 1, rdy);
      step(1, 1, 1, 2'd3, 0, 0, rdy);
      chk("rst-full o0_valid", o0_valid, 0);
      chk("rst-full o1_valid", o1_valid, 0);
      chk("rst-full cnt0", cnt0, 0);
      chk("rst-full cnt1", cnt1, 0);
      step(0, 0, 0, 2'd0, 0, 0, rdy);
      chk("rst-full word dropped", o1_valid, 0);

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 63) == 0, 1'($urandom), 1'($urandom), 2'($urandom),
              1'($urandom), 1'($urandom), rdy);
      end
      step(0, 0, 0, 2'd0, 0, 0, rdy);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
